// File: rtl/result_port_writer.sv
// result_port_writer: buffers result words from the core in a small FIFO and
// issues each one as a single word write on the addr/data/wen port. Every write
// is held through stalls, and the writes are separated by one idle wen cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no write in flight; the FIFO head is loaded as soon as one exists
// S_WRITE | mem_wen high; held while mem_stall, completes on an unstalled edge
// S_GAP   | mem_wen low for one cycle; then load the next word or return to idle
module result_port_writer #(
   parameter int          DEPTH     = 4,
   parameter logic [29:0] BASE_ADDR = 30'd0,
   parameter int          ADDR_INC  = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_valid,
   input  logic [31:0] push_data,
   output logic        push_ready,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wen,
   input  logic        mem_stall,
   output logic        idle,
   output logic [15:0] sent_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [29:0]   INC      = 30'(ADDR_INC);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   fifo_q [DEPTH];
   logic [31:0]   fifo_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [29:0]   offset_q, offset_d;
   logic [29:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          wen_q, wen_d;
   logic [15:0]   sent_q, sent_d;

   logic          push_fire;
   logic          pop_fire;
   logic          fifo_empty;

   // Readiness comes from the registered count only, so a pop in the same
   // cycle never lets a full FIFO take another word.
   assign push_ready = (count_q != FULL_CNT);
   assign push_fire  = push_valid && push_ready;
   assign fifo_empty = (count_q == '0);
   // The head entry is popped on the edge its write completes.
   assign pop_fire   = (state_q == S_WRITE) && !mem_stall;

   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_wen    = wen_q;
   assign sent_count = sent_q;
   assign idle       = (state_q == S_IDLE) && fifo_empty;

   // FIFO storage, pointers and occupancy
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_fire) begin
         fifo_d[wr_ptr_q] = push_data;
         wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (pop_fire) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_fire, pop_fire})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Write sequencing: next state and registered bus outputs
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wen_d    = wen_q;
      offset_d = offset_q;
      sent_d   = sent_q;
      case (state_q)
         S_IDLE: begin
            wen_d = 1'b0;
            if (!fifo_empty) begin
               addr_d  = BASE_ADDR + offset_q;
               wdata_d = fifo_q[rd_ptr_q];
               wen_d   = 1'b1;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (!mem_stall) begin
               sent_d   = sent_q + 16'd1;
               offset_d = offset_q + INC;
               wen_d    = 1'b0;
               state_d  = S_GAP;
            end
         end
         S_GAP: begin
            wen_d = 1'b0;
            if (!fifo_empty) begin
               addr_d  = BASE_ADDR + offset_q;
               wdata_d = fifo_q[rd_ptr_q];
               wen_d   = 1'b1;
               state_d = S_WRITE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            wen_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset drops wen at once and discards queued words
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= 32'd0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         offset_q <= 30'd0;
         addr_q   <= BASE_ADDR;
         wdata_q  <= 32'd0;
         wen_q    <= 1'b0;
         sent_q   <= 16'd0;
      end else begin
         state_q  <= state_d;
         fifo_q   <= fifo_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         offset_q <= offset_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wen_q    <= wen_d;
         sent_q   <= sent_d;
      end
   end

endmodule

// File: tb/tb_result_port_writer.sv
// Bench for result_port_writer: a default instance (fixed address) and an
// incrementing-address instance near the top of the address space.
module tb_result_port_writer;

   logic        clk;
   logic        rst_n;

   logic        pv_a, pr_a, wen_a, stall_a, idle_a;
   logic [31:0] pd_a, wd_a;
   logic [29:0] addr_a;
   logic [15:0] sc_a;

   logic        pv_b, pr_b, wen_b, stall_b, idle_b;
   logic [31:0] pd_b, wd_b;
   logic [29:0] addr_b;
   logic [15:0] sc_b;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t sb_a[$];
   wr_t sb_b[$];
   wr_t e_a, e_b;

   int n_pass  = 0;
   int n_total = 0;

   logic        pw_a, ps_a, pw_b;
   logic [29:0] pa_a;
   logic [31:0] pdat_a;

   result_port_writer u_dut (
      .clk        (clk),
      .rst        (rst_n),
      .push_valid (pv_a),
      .push_data  (pd_a),
      .push_ready (pr_a),
      .mem_addr   (addr_a),
      .mem_wdata  (wd_a),
      .mem_wen    (wen_a),
      .mem_stall  (stall_a),
      .idle       (idle_a),
      .sent_count (sc_a)
   );

   result_port_writer #(
      .DEPTH     (4),
      .BASE_ADDR (30'h3FFFFFFE),
      .ADDR_INC  (1)
   ) u_inc (
      .clk        (clk),
      .rst        (rst_n),
      .push_valid (pv_b),
      .push_data  (pd_b),
      .push_ready (pr_b),
      .mem_addr   (addr_b),
      .mem_wdata  (wd_b),
      .mem_wen    (wen_b),
      .mem_stall  (stall_b),
      .idle       (idle_b),
      .sent_count (sc_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Called just after a rising edge; drives the word across the next edge.
   task automatic push_a(input logic [31:0] d, input bit acc, input bit wr);
      check("a_push_ready", pr_a, acc);
      pv_a = 1'b1;
      pd_a = d;
      if (acc && wr) sb_a.push_back('{addr: 30'd0, data: d});
      @(posedge clk);
      #1;
      pv_a = 1'b0;
   endtask

   task automatic push_b(input logic [31:0] d, input logic [29:0] exp_addr);
      check("b_push_ready", pr_b, 1'b1);
      pv_b = 1'b1;
      pd_b = d;
      sb_b.push_back('{addr: exp_addr, data: d});
      @(posedge clk);
      #1;
      pv_b = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor A: a write completes on the edge after wen && !stall is seen.
   always @(negedge clk) begin
      if (!rst_n) begin
         pw_a = 1'b0;
         ps_a = 1'b0;
      end else begin
         if (pw_a && ps_a) begin
            check("a_hold_wen", wen_a, 1'b1);
            if (wen_a) begin
               check("a_hold_addr", addr_a, pa_a);
               check("a_hold_data", wd_a, pdat_a);
            end
         end else if (pw_a && !ps_a) begin
            check("a_gap_wen", wen_a, 1'b0);
         end
         if (wen_a && !stall_a) begin
            if (sb_a.size() == 0) begin
               n_total++;
               $display("FAIL a_unexpected_write: got addr 0x%0h data 0x%0h, none expected", addr_a, wd_a);
            end else begin
               e_a = sb_a.pop_front();
               check("a_write_addr", addr_a, e_a.addr);
               check("a_write_data", wd_a, e_a.data);
            end
         end
         pw_a   = wen_a;
         ps_a   = stall_a;
         pa_a   = addr_a;
         pdat_a = wd_a;
      end
   end

   // Monitor B: never stalled, so every wen cycle is a completed write.
   always @(negedge clk) begin
      if (!rst_n) begin
         pw_b = 1'b0;
      end else begin
         if (pw_b) check("b_gap_wen", wen_b, 1'b0);
         if (wen_b && !stall_b) begin
            if (sb_b.size() == 0) begin
               n_total++;
               $display("FAIL b_unexpected_write: got addr 0x%0h data 0x%0h, none expected", addr_b, wd_b);
            end else begin
               e_b = sb_b.pop_front();
               check("b_write_addr", addr_b, e_b.addr);
               check("b_write_data", wd_b, e_b.data);
            end
         end
         pw_b = wen_b;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      rst_n   = 1'b0;
      pv_a    = 1'b0; pd_a = 32'd0; stall_a = 1'b0;
      pv_b    = 1'b0; pd_b = 32'd0; stall_b = 1'b0;
      cycles(2);

      // reset state
      check("rst_wen",        wen_a,  1'b0);
      check("rst_addr",       addr_a, 30'd0);
      check("rst_wdata",      wd_a,   32'd0);
      check("rst_sent",       sc_a,   16'd0);
      check("rst_push_ready", pr_a,   1'b1);
      check("rst_idle",       idle_a, 1'b1);
      check("rst_addr_b",     addr_b, 30'h3FFFFFFE);
      rst_n = 1'b1;
      cycles(1);

      // 1: single unstalled write
      push_a(32'd150, 1, 1);
      cycles(1);
      check("t1_wen_high", wen_a, 1'b1);
      cycles(1);
      check("t1_wen_low",  wen_a, 1'b0);
      check("t1_sent",     sc_a,  16'd1);
      check("t1_gap_idle", idle_a, 1'b0);
      cycles(1);
      check("t1_idle", idle_a, 1'b1);

      // 2: write held through three stalled cycles
      stall_a = 1'b1;
      push_a(32'hDEADBEEF, 1, 1);
      cycles(4);
      check("t2_wen_held",  wen_a, 1'b1);
      check("t2_sent_held", sc_a,  16'd1);
      stall_a = 1'b0;
      cycles(1);
      check("t2_wen_low", wen_a, 1'b0);
      check("t2_sent",    sc_a,  16'd2);

      // 3: fill while stalled, fifth word dropped
      stall_a = 1'b1;
      push_a(32'h1111_0000, 1, 1);
      push_a(32'h2222_0001, 1, 1);
      push_a(32'h3333_0002, 1, 1);
      push_a(32'h4444_0003, 1, 1);
      push_a(32'h5555_0004, 0, 0);
      check("t3_full_ready", pr_a, 1'b0);
      stall_a = 1'b0;
      cycles(12);
      check("t3_sent",  sc_a,   16'd6);
      check("t3_idle",  idle_a, 1'b1);
      check("t3_ready", pr_a,   1'b1);

      // 4: incrementing address wraps modulo 2^30
      push_b(32'hA0, 30'h3FFFFFFE);
      push_b(32'hA1, 30'h3FFFFFFF);
      push_b(32'hA2, 30'h00000000);
      cycles(10);
      check("t4_sent", sc_b,   16'd3);
      check("t4_idle", idle_b, 1'b1);

      // 5: reset during a stalled write with two words queued
      stall_a = 1'b1;
      push_a(32'hBAD0_0001, 1, 0);
      push_a(32'hBAD0_0002, 1, 0);
      cycles(1);
      check("t5_wen_before", wen_a, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_wen_async",  wen_a,  1'b0);
      check("t5_idle_rst",   idle_a, 1'b1);
      check("t5_sent_rst",   sc_a,   16'd0);
      @(posedge clk);
      #1;
      stall_a = 1'b0;
      rst_n   = 1'b1;
      cycles(10);
      check("t5_idle_after", idle_a, 1'b1);
      check("t5_sent_after", sc_a,   16'd0);
      check("t5_wen_after",  wen_a,  1'b0);

      // 6: push/pop on the same edge at DEPTH-1
      stall_a = 1'b1;
      push_a(32'h6000_0000, 1, 1);
      push_a(32'h6000_0001, 1, 1);
      push_a(32'h6000_0002, 1, 1);
      stall_a = 1'b0;
      push_a(32'h6000_0003, 1, 1);
      push_a(32'h6000_0004, 1, 1);
      push_a(32'h6000_0005, 0, 0);
      cycles(12);
      check("t6_sent", sc_a,   16'd5);
      check("t6_idle", idle_a, 1'b1);

      check("sb_a_empty", sb_a.size(), 0);
      check("sb_b_empty", sb_b.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
